// File: rtl/pipe_pkg.sv
// Shared types and default stage widths for the pipeline stage buffers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // Default widths used by the per-stage instances.
  localparam int unsigned IF_ID_CTRL_W   = 1;
  localparam int unsigned IF_ID_DATA_W   = 64;
  localparam int unsigned ID_EX_CTRL_W   = 10;
  localparam int unsigned ID_EX_DATA_W   = 288;
  localparam int unsigned EX_MEM_CTRL_W  = 5;
  localparam int unsigned EX_MEM_DATA_W  = 141;
  localparam int unsigned MEM_WB_CTRL_W  = 2;
  localparam int unsigned MEM_WB_DATA_W  = 133;
  localparam int unsigned STALL_CNT_W_DF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment unless already at the all-ones ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush to a bubble and a saturating back-pressure counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = 10,
  parameter int unsigned DATA_W      = 288,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  // State and storage registers; reset clears everything, flush only the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next-state and storage update; flush empties the stage and drops any input.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Handshake and output decode from the current state.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
    in_ready  = in_ready_q;
    in_fire   = in_valid & in_ready_q;
    out_fire  = out_valid & out_ready;
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_ni (reset),
    .inc_i  (out_valid & ~out_ready),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf.
module tb_pipe_stage_buf;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 288;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [SW-1:0] stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 10'h155, 288'hAA);
    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_ctrl",  out_ctrl, 0);
    check("rst_data",  out_data, 0);
    check("rst_ready", in_ready, 1);
    check("rst_stall", stall_cnt, 0);

    // Streaming at full rate.
    reset = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      step();
      check("str_valid", out_valid, 1);
      check("str_data",  out_data, DW'(i));
      check("str_ctrl",  out_ctrl, CW'(i));
      check("str_ready", in_ready, 1);
    end
    drive(1'b0, 10'h0, 288'h0);
    step();
    check("str_drain_valid", out_valid, 0);
    check("str_drain_ctrl",  out_ctrl, 0);
    check("str_drain_data",  out_data, 4);
    check("str_stall",       stall_cnt, 0);

    // Back-pressure: 5 at head, 6 into skid, 7 held upstream.
    out_ready = 1'b0;
    drive(1'b1, 10'h5, 288'h5); step();
    check("bp_head5", out_data, 5);
    check("bp_rdy1",  in_ready, 1);
    drive(1'b1, 10'h6, 288'h6); step();
    check("bp_rdy0",  in_ready, 0);
    check("bp_hold5", out_data, 5);
    drive(1'b1, 10'h7, 288'h7); step();
    check("bp_hold5b", out_data, 5);
    step();
    check("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    step();
    check("bp_out6",   out_data, 6);
    check("bp_rdy_up", in_ready, 1);
    step();
    check("bp_out7",   out_data, 7);
    check("bp_ctrl7",  out_ctrl, 7);
    drive(1'b0, 10'h0, 288'h0); step();
    check("bp_empty",  out_valid, 0);
    check("bp_stall",  stall_cnt, 3);

    // Flush in ST_TWO with input offered.
    out_ready = 1'b0;
    drive(1'b1, 10'h8, 288'h8); step();
    drive(1'b1, 10'hA, 288'hA); step();
    check("fl_two_rdy", in_ready, 0);
    drive(1'b1, 10'h9, 288'h9); flush = 1'b1; step();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl",  out_ctrl, 0);
    check("fl_ready", in_ready, 1);
    check("fl_stall", stall_cnt, 5);
    drive(1'b0, 10'h0, 288'h0); out_ready = 1'b1; step();
    check("fl_no9", out_valid, 0);

    // Flush with out_fire and in_fire in ST_ONE: head consumed, input dropped.
    drive(1'b1, 10'hB, 288'hB); step();
    check("fl1_headB", out_data, 288'hB);
    drive(1'b1, 10'h9, 288'h9); flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 10'h0, 288'h0);
    check("fl1_valid", out_valid, 0);
    check("fl1_data",  out_data, 288'hB);
    step();
    check("fl1_still", out_valid, 0);

    // Bubble control.
    drive(1'b1, 10'h3FF, 288'h55); step();
    check("bub_ctrl_on", out_ctrl, 10'h3FF);
    drive(1'b0, 10'h3FF, 288'h0); step();
    check("bub_valid", out_valid, 0);
    check("bub_ctrl",  out_ctrl, 0);
    check("bub_data",  out_data, 288'h55);

    // Stall counter saturation (starts from 5).
    out_ready = 1'b0;
    drive(1'b1, 10'h66, 288'h66); step();
    drive(1'b0, 10'h0, 288'h0);
    for (int unsigned i = 0; i < 20; i++) step();
    check("sat_15", stall_cnt, 15);
    step();
    check("sat_hold", stall_cnt, 15);
    check("sat_data", out_data, 288'h66);

    // Mid-stream reset in ST_ONE together with flush.
    reset = 1'b0; flush = 1'b1; drive(1'b1, 10'h3, 288'h3); step();
    check("mrst_valid", out_valid, 0);
    check("mrst_ctrl",  out_ctrl, 0);
    check("mrst_data",  out_data, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_stall", stall_cnt, 0);

    // Normal operation resumes.
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 10'h77, 288'h77); step();
    check("resume_data",  out_data, 288'h77);
    check("resume_valid", out_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
